// File: rtl/booth_pkg.sv
// Shared types and default sizes for the radix-4 Booth multiplier datapath.
// Used by the Booth encoder (producer) and the partial-product accumulator.
package booth_pkg;

  localparam int unsigned A_WIDTH_DEF    = 24;
  localparam int unsigned NUM_DIGITS_DEF = 4;
  localparam int unsigned P_WIDTH_DEF    = A_WIDTH_DEF + 2 * NUM_DIGITS_DEF;

  // One encoded radix-4 Booth digit: sign plus one-hot magnitude (1 or 2).
  typedef struct packed {
    logic neg;
    logic a1;
    logic a2;
  } booth_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } booth_acc_state_t;

endpackage

// File: rtl/booth_pp_decoder_acc_if.sv
// Handshake bundle for the Booth partial-product accumulator.
//   start_* : multiplicand hand-off (valid/ready)
//   dig_*   : encoded Booth digit stream, LSB digit first (valid/ready)
//   out_*   : signed product and illegal-digit flag (valid/ready)
// master = environment side, slave = accumulator side.
interface booth_pp_decoder_acc_if
  import booth_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned P_WIDTH = P_WIDTH_DEF
);

  logic               start_valid;
  logic               start_ready;
  logic [A_WIDTH-1:0] start_mcand;

  logic               dig_valid;
  logic               dig_ready;
  logic               dig_neg;
  logic               dig_A;
  logic               dig_2A;

  logic               out_valid;
  logic               out_ready;
  logic [P_WIDTH-1:0] out_product;
  logic               out_err;

  modport master (
    output start_valid, start_mcand,
    input  start_ready,
    output dig_valid, dig_neg, dig_A, dig_2A,
    input  dig_ready,
    input  out_valid, out_product, out_err,
    output out_ready
  );

  modport slave (
    input  start_valid, start_mcand,
    output start_ready,
    input  dig_valid, dig_neg, dig_A, dig_2A,
    output dig_ready,
    output out_valid, out_product, out_err,
    input  out_ready
  );

endinterface

// File: rtl/booth_pp_select.sv
// Combinational Booth digit decode: digit + multiplicand -> sign-extended
// partial product (0, +-A, +-2A) and an illegal-digit flag.
//   digit     : {neg, a1, a2} encoded Booth digit
//   mcand     : signed multiplicand
//   pp_c      : P_WIDTH two's-complement partial product (unshifted)
//   illegal_c : a1 and a2 both set; partial product forced to zero
module booth_pp_select
  import booth_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned P_WIDTH = P_WIDTH_DEF
) (
  input  booth_digit_t       digit,
  input  logic [A_WIDTH-1:0] mcand,
  output logic [P_WIDTH-1:0] pp_c,
  output logic               illegal_c
);

  logic [P_WIDTH-1:0] ext;
  logic [P_WIDTH-1:0] mag;

  assign ext = {{(P_WIDTH - A_WIDTH){mcand[A_WIDTH-1]}}, mcand};

  // Negating a zero magnitude yields zero, so "-0" digits contribute nothing.
  always_comb begin
    illegal_c = digit.a1 & digit.a2;
    mag       = '0;
    if (!illegal_c) begin
      if (digit.a2) begin
        mag = ext << 1;
      end else if (digit.a1) begin
        mag = ext;
      end
    end
    pp_c = digit.neg ? (~mag + P_WIDTH'(1)) : mag;
  end

endmodule

// File: rtl/booth_pp_decoder_acc.sv
// Radix-4 Booth digit consumer: latches a signed multiplicand, accumulates one
// shifted partial product per accepted digit, then presents the signed product.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of booth_pp_decoder_acc_if (start / dig / out)
module booth_pp_decoder_acc
  import booth_pkg::*;
#(
  parameter int unsigned A_WIDTH    = A_WIDTH_DEF,
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned P_WIDTH    = A_WIDTH + 2 * NUM_DIGITS
) (
  input logic                     clk,
  input logic                     rst_n,
  booth_pp_decoder_acc_if.slave   bus
);

  localparam int unsigned CNT_WIDTH = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_DIGITS - 1);

  booth_acc_state_t     state_q, state_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d;
  logic [A_WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  booth_digit_t         digit;
  logic [P_WIDTH-1:0]   pp_c;
  logic                 illegal_c;

  assign digit = '{neg: bus.dig_neg, a1: bus.dig_A, a2: bus.dig_2A};

  booth_pp_select #(
    .A_WIDTH (A_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_pp_select (
    .digit     (digit),
    .mcand     (mcand_q),
    .pp_c      (pp_c),
    .illegal_c (illegal_c)
  );

  // Next-state and datapath update; each digit is weighted by 4^cnt.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          mcand_d = bus.start_mcand;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (bus.dig_valid) begin
          acc_d = acc_q + (pp_c << {cnt_q, 1'b0});
          cnt_d = cnt_q + CNT_WIDTH'(1);
          err_d = err_q | illegal_c;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      acc_q           <= '0;
      mcand_q         <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      bus.start_ready <= 1'b1;
      bus.dig_ready   <= 1'b0;
      bus.out_valid   <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      mcand_q         <= mcand_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      bus.start_ready <= (state_d == ST_IDLE);
      bus.dig_ready   <= (state_d == ST_ACC);
      bus.out_valid   <= (state_d == ST_DONE);
    end
  end

  // Product and error flag come straight from their registers.
  assign bus.out_product = acc_q;
  assign bus.out_err     = err_q;

endmodule
